// File: rtl/plic_claim_engine.sv
// Claim/complete sequencer for the PLIC claim register. It also arbitrates the shared
// PLIC slave port: the engine has priority, and the CPU MMIO path is stalled or passed through.
module plic_claim_engine #(
    parameter logic [31:0] PLIC_CLAIM_ADDR = 32'h0C200004,
    parameter int          ID_W            = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            engine_en,
    input  logic            external_irq,
    output logic [31:0]     m_addr,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_read_en,
    input  logic [31:0]     m_rdata,
    input  logic [31:0]     cpu_addr,
    input  logic [31:0]     cpu_wdata,
    input  logic [3:0]      cpu_wstrb,
    input  logic            cpu_read_en,
    output logic [31:0]     cpu_rdata,
    output logic            cpu_stall,
    output logic            irq_valid,
    output logic [ID_W-1:0] irq_id,
    input  logic            irq_ready,
    input  logic            irq_done,
    output logic            busy,
    output logic [15:0]     serviced_cnt,
    output logic [7:0]      spurious_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAIM,
        ST_OFFER,
        ST_SERVICE,
        ST_COMPLETE
    } state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] irq_id_reg;
    logic [15:0]     serviced_cnt_reg;
    logic [7:0]      spurious_cnt_reg;

    logic [ID_W-1:0] claim_id;
    logic            claim_zero;
    logic            cpu_req;
    logic            cpu_claim_hit;
    logic            claim_blocked;

    assign claim_id      = m_rdata[ID_W-1:0];
    assign claim_zero    = (claim_id == '0);
    assign cpu_req       = cpu_read_en | (|cpu_wstrb);
    assign cpu_claim_hit = (cpu_addr == PLIC_CLAIM_ADDR);
    assign claim_blocked = cpu_claim_hit && (engine_en || busy);

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            irq_id_reg       <= '0;
            serviced_cnt_reg <= '0;
            spurious_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_CLAIM) begin
                irq_id_reg <= claim_id;
                if (claim_zero && (spurious_cnt_reg != 8'hFF)) begin
                    spurious_cnt_reg <= spurious_cnt_reg + 8'd1;
                end
            end
            if (state_reg == ST_COMPLETE) begin
                serviced_cnt_reg <= serviced_cnt_reg + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:     if (engine_en && external_irq) state_next = ST_CLAIM;
            ST_CLAIM:    state_next = claim_zero ? ST_IDLE : ST_OFFER;
            // irq_done is deliberately not looked at here; the core must pulse it in SERVICE.
            ST_OFFER:    if (irq_ready) state_next = ST_SERVICE;
            ST_SERVICE:  if (irq_done) state_next = ST_COMPLETE;
            ST_COMPLETE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Port mux: engine owns CLAIM/COMPLETE; otherwise an unblocked CPU request passes through.
    always_comb begin
        m_addr    = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_read_en = 1'b0;
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        if (state_reg == ST_CLAIM) begin
            m_addr    = PLIC_CLAIM_ADDR;
            m_read_en = 1'b1;
            cpu_stall = cpu_req;
        end else if (state_reg == ST_COMPLETE) begin
            m_addr    = PLIC_CLAIM_ADDR;
            m_wdata   = {{(32-ID_W){1'b0}}, irq_id_reg};
            m_wstrb   = 4'hF;
            cpu_stall = cpu_req;
        end else if (cpu_req && !claim_blocked) begin
            m_addr    = cpu_addr;
            m_wdata   = cpu_wdata;
            m_wstrb   = cpu_wstrb;
            m_read_en = cpu_read_en;
            cpu_rdata = m_rdata;
        end
    end

    assign irq_valid    = (state_reg == ST_OFFER);
    assign irq_id       = irq_id_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign serviced_cnt = serviced_cnt_reg;
    assign spurious_cnt = spurious_cnt_reg;

endmodule
